uram_block_fifo: RTL and testbench

- Block FIFO for 128-bit Simon cipher blocks, backed by one uram_wrapper instance that is instantiated outside this block.
- Accepts blocks on a valid/ready stream and drives the uram_wrapper port signals.
- Stores each block as two 72-bit URAM rows: port A writes, port B reads.
- Presents blocks in order on a registered valid/ready output stream to the cipher core.

---
 rtl/uram_fifo_pkg.sv | 25 ++
 rtl/uram_block_fifo.sv | 157 +++++++++++++++
 tb/tb_uram_block_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uram_fifo_pkg.sv
// Shared types and constants for the URAM-backed 128-bit block FIFO.
package uram_fifo_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LO,
        R_HI,
        R_CAP
    } rd_state_t;

    localparam int unsigned URAM_ROWS   = 4096;
    localparam int unsigned URAM_ADDR_W = 23;
    localparam int unsigned URAM_DATA_W = 72;
    localparam logic [8:0]  BWE_ALL     = 9'h1FF;

    // Row index within a block: low 64 bits live in half 0, high 64 bits in half 1.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // One 64-bit block half packed into a 72-bit URAM row; the spare byte is zero.
    function automatic logic [URAM_DATA_W-1:0] pack_row(input logic [63:0] half_data);
        return {8'h00, half_data};
    endfunction

endpackage

// File: rtl/uram_block_fifo.sv
// Block FIFO for 128-bit cipher blocks stored as two 72-bit rows in an external URAM.
// Port A writes (lo half on the handshake cycle, hi half on the next); port B reads.
module uram_block_fifo
    import uram_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                    clk,
    input  logic                    rst_async,
    input  logic [127:0]            s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [127:0]            m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DEPTH_LOG2:0]     level,
    output logic [71:0]             uram_din_a,
    output logic [8:0]              uram_bwe_a,
    output logic [22:0]             uram_addr_a,
    output logic                    uram_en_a,
    output logic                    uram_we_a,
    output logic [71:0]             uram_din_b,
    output logic [8:0]              uram_bwe_b,
    output logic [22:0]             uram_addr_b,
    output logic                    uram_en_b,
    output logic                    uram_we_b,
    input  logic [71:0]             uram_dout_b
);

    localparam logic [DEPTH_LOG2:0]   CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Row address {ptr, half}, zero-extended to the URAM address width.
    function automatic logic [URAM_ADDR_W-1:0] row_addr(input logic [DEPTH_LOG2-1:0] ptr,
                                                       input logic half);
        return {{(URAM_ADDR_W-DEPTH_LOG2-1){1'b0}}, ptr, half};
    endfunction

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   rd_avail_q, rd_avail_d;
    logic                  hi_pending_q, hi_pending_d;
    logic [63:0]           hi_data_q, hi_data_d;
    logic [63:0]           lo_q, lo_d;
    rd_state_t             state_q, state_d;
    logic                  m_valid_q, m_valid_d;
    logic [127:0]          m_data_q, m_data_d;

    logic push;
    logic commit;
    logic pop;
    logic start;
    logic dout_b_unused;

    assign dout_b_unused = ^uram_dout_b[71:64];

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign level   = level_q;

    // Handshakes, counter/pointer updates, read sequencing and URAM port drive.
    always_comb begin
        s_ready = rst_async && !hi_pending_q && (level_q < CAPACITY);
        push    = s_valid && s_ready;
        commit  = hi_pending_q;
        pop     = m_valid_q && m_ready;
        // A block committing this cycle may start its read right away, so the
        // FSM sees it one cycle before rd_avail_q does; the rd_avail update
        // below nets commit against start so the count stays consistent.
        start   = (state_q == R_IDLE) && !m_valid_q && ((rd_avail_q != '0) || commit);

        hi_pending_d = push;
        hi_data_d    = push ? s_data[127:64] : hi_data_q;
        wr_ptr_d     = commit ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

        case ({commit, pop})
            2'b10:   level_d = level_q + CNT_ONE;
            2'b01:   level_d = level_q - CNT_ONE;
            default: level_d = level_q;
        endcase

        case ({commit, start})
            2'b10:   rd_avail_d = rd_avail_q + CNT_ONE;
            2'b01:   rd_avail_d = rd_avail_q - CNT_ONE;
            default: rd_avail_d = rd_avail_q;
        endcase

        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        lo_d      = lo_q;
        m_data_d  = m_data_q;
        m_valid_d = pop ? 1'b0 : m_valid_q;

        case (state_q)
            R_IDLE: if (start) state_d = R_LO;
            R_LO:   state_d = R_HI;
            R_HI: begin
                lo_d    = uram_dout_b[63:0];
                state_d = R_CAP;
            end
            R_CAP: begin
                m_data_d  = {uram_dout_b[63:0], lo_q};
                m_valid_d = 1'b1;
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                state_d   = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase

        uram_en_a   = push || hi_pending_q;
        uram_we_a   = uram_en_a;
        uram_bwe_a  = uram_en_a ? BWE_ALL : '0;
        uram_addr_a = row_addr(wr_ptr_q, hi_pending_q ? HALF_HI : HALF_LO);
        if (hi_pending_q)
            uram_din_a = pack_row(hi_data_q);
        else if (push)
            uram_din_a = pack_row(s_data[63:0]);
        else
            uram_din_a = '0;

        uram_en_b   = (state_q == R_LO) || (state_q == R_HI);
        uram_addr_b = row_addr(rd_ptr_q, (state_q == R_HI) ? HALF_HI : HALF_LO);
        uram_din_b  = '0;
        uram_bwe_b  = '0;
        uram_we_b   = 1'b0;
    end

    // State registers, cleared asynchronously; any in-flight block is dropped.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rd_avail_q   <= '0;
            hi_pending_q <= 1'b0;
            hi_data_q    <= '0;
            lo_q         <= '0;
            state_q      <= R_IDLE;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rd_avail_q   <= rd_avail_d;
            hi_pending_q <= hi_pending_d;
            hi_data_q    <= hi_data_d;
            lo_q         <= lo_d;
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
        end
    end

endmodule

// File: tb/tb_uram_block_fifo.sv
// Self-checking bench for uram_block_fifo with a behavioural URAM beside the DUT.
module tb_uram_block_fifo;

    logic         clk = 1'b0;
    logic         rst_async;
    logic [127:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [2:0]   level;
    logic [71:0]  uram_din_a;
    logic [8:0]   uram_bwe_a;
    logic [22:0]  uram_addr_a;
    logic         uram_en_a;
    logic         uram_we_a;
    logic [71:0]  uram_din_b;
    logic [8:0]   uram_bwe_b;
    logic [22:0]  uram_addr_b;
    logic         uram_en_b;
    logic         uram_we_b;
    logic [71:0]  uram_dout_b;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    int unsigned  wr_blk  = 0;
    logic [127:0] sb[$];

    always #5 clk = ~clk;

    uram_block_fifo #(.DEPTH_LOG2(2)) dut (
        .clk         (clk),
        .rst_async   (rst_async),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .level       (level),
        .uram_din_a  (uram_din_a),
        .uram_bwe_a  (uram_bwe_a),
        .uram_addr_a (uram_addr_a),
        .uram_en_a   (uram_en_a),
        .uram_we_a   (uram_we_a),
        .uram_din_b  (uram_din_b),
        .uram_bwe_b  (uram_bwe_b),
        .uram_addr_b (uram_addr_b),
        .uram_en_b   (uram_en_b),
        .uram_we_b   (uram_we_b),
        .uram_dout_b (uram_dout_b)
    );

    // Behavioural URAM: byte-enabled write on A, registered read on B (no OREG).
    logic [71:0] mem [0:4095];
    always @(posedge clk) begin
        if (uram_en_a && uram_we_a)
            for (int b = 0; b < 9; b++)
                if (uram_bwe_a[b]) mem[uram_addr_a[11:0]][b*8 +: 8] <= uram_din_a[b*8 +: 8];
        if (uram_en_b) uram_dout_b <= mem[uram_addr_b[11:0]];
    end

    typedef struct {
        logic         s_valid;
        logic         m_ready;
        logic         exp_s_ready;
        logic         exp_en_a;
        logic [22:0]  exp_addr_a;
        logic [71:0]  exp_din_a;
        logic         exp_en_b;
        logic [22:0]  exp_addr_b;
        logic         exp_m_valid;
        logic [127:0] exp_m_data;
        logic [2:0]   exp_level;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Assert reset from any point, check the cleared outputs, release on a negedge.
    task automatic apply_reset();
        rst_async = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_en_a", uram_en_a, 0);
        chk("rst_en_b", uram_en_b, 0);
        chk("rst_level", level, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_async = 1'b1;
        #1;
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_level", level, 0);
        chk("post_rst_m_valid", m_valid, 0);
        sb.delete();
        wr_blk = 0;
        @(negedge clk);
    endtask

    // Offer one block until accepted; checks both row writes against the bench's own pointer.
    task automatic push(input logic [127:0] d, input int unsigned budget, output bit ok);
        logic [1:0] wp;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int unsigned i = 0; i < budget; i++) begin
            #1;
            if (s_ready) begin
                ok = 1'b1;
                wp = 2'(wr_blk % 4);
                chk("wr_lo_addr", uram_addr_a, {wp, 1'b0});
                chk("wr_lo_din", uram_din_a, {8'h00, d[63:0]});
                sb.push_back(d);
                wr_blk++;
                @(negedge clk);
                #1;
                chk("wr_hi_en", uram_en_a, 1);
                chk("wr_hi_addr", uram_addr_a, {wp, 1'b1});
                chk("wr_hi_din", uram_din_a, {8'h00, d[127:64]});
                chk("wr_hi_s_ready", s_ready, 0);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // Pop n blocks against the scoreboard; mode 1 toggles m_ready randomly.
    task automatic pop_n(input int unsigned n, input bit mode, input int unsigned budget);
        int unsigned  got = 0;
        bit           held = 1'b0;
        logic [127:0] hold_data = '0;
        logic [127:0] exp;
        for (int unsigned c = 0; c < budget; c++) begin
            m_ready = mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_data);
            end
            if (uram_en_b) chk("rd_addr_range", uram_addr_b >> 3, 0);
            held = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        chk("m_data", m_data, exp);
                    end
                    got++;
                end else begin
                    held      = 1'b1;
                    hold_data = m_data;
                end
            end
            @(negedge clk);
            if (got == n) break;
        end
        m_ready = 1'b0;
        chk("pop_count", got, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic [63:0]  d_lo;
        logic [63:0]  d_hi;
        logic [127:0] blk[5];
        bit           ok;
        bit           found;

        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_async = 1'b1;
        @(negedge clk);

        // Test 1: single block, cycle-by-cycle table from the handshake cycle.
        apply_reset();
        d    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d_lo = d[63:0];
        d_hi = d[127:64];
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 23'd0, {8'h00, d_lo}, 1'b0, 23'd0, 1'b0, 128'd0, 3'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 23'd1, {8'h00, d_hi}, 1'b0, 23'd0, 1'b0, 128'd0, 3'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'd0, 72'd0,         1'b1, 23'd0, 1'b0, 128'd0, 3'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'd0, 72'd0,         1'b1, 23'd1, 1'b0, 128'd0, 3'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'd0, 72'd0,         1'b0, 23'd0, 1'b0, 128'd0, 3'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'd0, 72'd0,         1'b0, 23'd0, 1'b1, d,      3'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 23'd0, 72'd0,         1'b0, 23'd0, 1'b1, d,      3'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'd0, 72'd0,         1'b0, 23'd0, 1'b0, 128'd0, 3'd0};
        for (int i = 0; i < 8; i++) begin
            s_valid = vecs[i].s_valid;
            s_data  = d;
            m_ready = vecs[i].m_ready;
            #1;
            chk("t1_s_ready", s_ready, vecs[i].exp_s_ready);
            chk("t1_en_a", uram_en_a, vecs[i].exp_en_a);
            chk("t1_en_b", uram_en_b, vecs[i].exp_en_b);
            chk("t1_m_valid", m_valid, vecs[i].exp_m_valid);
            chk("t1_level", level, vecs[i].exp_level);
            if (vecs[i].exp_en_a) begin
                chk("t1_we_a", uram_we_a, 1);
                chk("t1_bwe_a", uram_bwe_a, 9'h1FF);
                chk("t1_addr_a", uram_addr_a, vecs[i].exp_addr_a);
                chk("t1_din_a", uram_din_a, vecs[i].exp_din_a);
            end
            if (vecs[i].exp_en_b) chk("t1_addr_b", uram_addr_b, vecs[i].exp_addr_b);
            if (vecs[i].exp_m_valid) chk("t1_m_data", m_data, vecs[i].exp_m_data);
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("t1_row0", mem[0], {8'h00, d_lo});
        chk("t1_row1", mem[1], {8'h00, d_hi});
        chk("t1_port_b_tied", {uram_we_b, uram_bwe_b, uram_din_b}, 0);

        // Tests 2 and 6: fill to capacity, hold the 5th block, pop with s_valid high.
        apply_reset();
        for (int k = 0; k < 5; k++) blk[k] = {4{32'hA000_0000 + 32'(k)}};
        for (int k = 0; k < 4; k++) begin
            push(blk[k], 10, ok);
            chk("t2_push_ok", ok, 1);
        end
        #1;
        chk("t2_full_level", level, 4);
        chk("t2_full_s_ready", s_ready, 0);
        push(blk[4], 8, ok);
        chk("t2_full_blocks_push", ok, 0);
        s_valid = 1'b1;
        s_data  = blk[4];
        m_ready = 1'b1;
        #1;
        chk("t6_pop_cycle_s_ready", s_ready, 0);
        chk("t6_pop_cycle_en_a", uram_en_a, 0);
        chk("t6_pop_cycle_level", level, 4);
        chk("t6_pop_m_valid", m_valid, 1);
        d = sb.pop_front();
        chk("t6_pop_m_data", m_data, d);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        chk("t6_after_pop_level", level, 3);
        chk("t6_after_pop_s_ready", s_ready, 1);
        push(blk[4], 2, ok);
        chk("t6_push_ok", ok, 1);
        pop_n(4, 1'b0, 200);
        #1;
        chk("t2_drained_level", level, 0);
        @(negedge clk);

        // Test 3: 10 blocks through a depth-4 FIFO, pointers wrap.
        apply_reset();
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    push({4{32'h0000_0100 + 32'(k)}}, 40, ok);
                    chk("t3_push_ok", ok, 1);
                end
            end
            pop_n(10, 1'b0, 400);
        join

        // Test 4: continuous input, random output backpressure, 200 blocks.
        apply_reset();
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    push({$urandom, $urandom, $urandom, $urandom}, 60, ok);
                    chk("t4_push_ok", ok, 1);
                end
            end
            pop_n(200, 1'b1, 6000);
        join
        #1;
        chk("t4_level_end", level, 0);
        @(negedge clk);

        // Test 5a: reset between the lo and hi row writes.
        apply_reset();
        s_valid = 1'b1;
        s_data  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        #1;
        chk("t5_hs_s_ready", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("t5_hi_write_en", uram_en_a, 1);
        apply_reset();
        repeat (8) @(negedge clk);
        #1;
        chk("t5a_idle_level", level, 0);
        chk("t5a_idle_m_valid", m_valid, 0);
        @(negedge clk);

        // Test 5b: reset while the read FSM is in R_HI.
        push(128'h1111_2222_3333_4444_5555_6666_7777_8888, 4, ok);
        chk("t5b_push_ok", ok, 1);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (uram_en_b && uram_addr_b[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5b_reached_r_hi", found, 1);
        apply_reset();
        repeat (8) @(negedge clk);
        #1;
        chk("t5b_idle_level", level, 0);
        chk("t5b_idle_m_valid", m_valid, 0);
        chk("t5b_idle_s_ready", s_ready, 1);
        @(negedge clk);
        push(128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C, 4, ok);
        chk("t5_next_push_ok", ok, 1);
        pop_n(1, 1'b0, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
